// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, issues word reads over req/ack and
// presents each instruction with its PC and PC+4 over valid/ready.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN, S_FAULT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        capture;
  logic        fault_next;
  logic        misaligned;
  logic        redir_ok;
  logic        outstanding;

  assign misaligned  = redirect & (|redirect_pc[1:0]);
  assign redir_ok    = redirect & ~(|redirect_pc[1:0]);
  // imem_req is registered, so the first REQ cycle after reset has no request in flight
  assign outstanding = imem_req & ~imem_ack;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    fault_next = fetch_fault;
    case (state)
      S_REQ: begin
        if (misaligned) begin
          fault_next = 1'b1;
          state_next = outstanding ? S_DRAIN : S_FAULT;
        end else if (redir_ok) begin
          pc_next    = redirect_pc;
          state_next = outstanding ? S_DRAIN : S_REQ;
        end else if (imem_req && imem_ack) begin
          capture    = 1'b1;
          pc_next    = pc + 32'd4;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (misaligned) begin
          fault_next = 1'b1;
          state_next = S_FAULT;
        end else if (redir_ok) begin
          pc_next    = redirect_pc;
          state_next = S_REQ;
        end else if (instr_ready) begin
          state_next = S_REQ;
        end
      end
      S_DRAIN: begin
        if (misaligned) fault_next = 1'b1;
        else if (redir_ok) pc_next = redirect_pc;
        if (imem_ack) state_next = fault_next ? S_FAULT : S_REQ;
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      imem_req       <= 1'b0;
      imem_addr      <= RESET_PC;
      instr_valid    <= 1'b0;
      instr          <= 32'h0000_0013;
      instr_pc       <= '0;
      instr_pc_plus4 <= '0;
      fetch_fault    <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      fetch_fault <= fault_next;
      imem_req    <= (state_next == S_REQ) || (state_next == S_DRAIN);
      instr_valid <= (state_next == S_HOLD);
      // address only moves when a fresh request starts; DRAIN keeps the old one
      if (state_next == S_REQ) imem_addr <= pc_next;
      if (capture) begin
        instr          <= imem_rdata;
        instr_pc       <= pc;
        instr_pc_plus4 <= pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with RESET_PC=0x100.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
    .fetch_fault(fetch_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL %s_req got %b exp 0", tag, imem_req); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL %s_addr got %h exp 00000100", tag, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL %s_valid got %b exp 0", tag, instr_valid); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL %s_instr got %h exp 00000013", tag, instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL %s_pc got %h exp 0", tag, instr_pc); end
    checks++; if (instr_pc_plus4 !== 32'h0) begin errors++; $display("FAIL %s_plus4 got %h exp 0", tag, instr_pc_plus4); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL %s_fault got %b exp 0", tag, fetch_fault); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
    redirect_pc = '0; instr_ready = 1'b0;
    tick(); tick();
    check_reset_values("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL t1_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL t1_addr got %h exp 00000100", imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got %b exp 0", instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %b exp 1", instr_valid); end
    checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL t1_instr got %h exp 00500093", instr); end
    checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL t1_pc got %h exp 00000100", instr_pc); end
    checks++; if (instr_pc_plus4 !== 32'h104) begin errors++; $display("FAIL t1_plus4 got %h exp 00000104", instr_pc_plus4); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t1_req_hold got %b exp 0", imem_req); end
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'h0050_0093)
        begin errors++; $display("FAIL t2_stall%0d got valid=%b req=%b instr=%h exp 1 0 00500093", i, instr_valid, imem_req, instr); end
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL t2_valid_drop got %b exp 0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104)
      begin errors++; $display("FAIL t2_next_req got req=%b addr=%h exp 1 00000104", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_pending();
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104 || instr_valid !== 1'b0)
        begin errors++; $display("FAIL t3_drain%0d got req=%b addr=%h valid=%b exp 1 00000104 0", i, imem_req, imem_addr, instr_valid); end
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0)
      begin errors++; $display("FAIL t3_newreq got req=%b addr=%h valid=%b exp 1 00000200 0", imem_req, imem_addr, instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0297;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== 32'h0000_0297)
      begin errors++; $display("FAIL t3_fetch got valid=%b pc=%h instr=%h exp 1 00000200 00000297", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_redirect_hold();
    for (int r = 0; r < 2; r++) begin
      redirect = 1'b1; redirect_pc = 32'h40; instr_ready = (r == 1);
      tick();
      redirect = 1'b0; instr_ready = 1'b0;
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40)
        begin errors++; $display("FAIL t4_redir_r%0d got valid=%b req=%b addr=%h exp 0 1 00000040", r, instr_valid, imem_req, imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'h0011_0113 + r;
      tick();
      imem_ack = 1'b0;
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr_pc_plus4 !== 32'h44)
        begin errors++; $display("FAIL t4_fetch_r%0d got valid=%b pc=%h plus4=%h exp 1 00000040 00000044", r, instr_valid, instr_pc, instr_pc_plus4); end
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++; if (imem_addr !== 32'h44) begin errors++; $display("FAIL t4_next_addr got %h exp 00000044", imem_addr); end
  endtask

  task automatic test_pc_wrap();
    // redirect together with ack: data is discarded, new address next cycle
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC)
      begin errors++; $display("FAIL t6_redir_ack got valid=%b req=%b addr=%h exp 0 1 fffffffc", instr_valid, imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_006F;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_pc !== 32'hFFFF_FFFC || instr_pc_plus4 !== 32'h0 || instr !== 32'h6F)
      begin errors++; $display("FAIL t6_wrap got pc=%h plus4=%h instr=%h exp fffffffc 0 0000006f", instr_pc, instr_pc_plus4, instr); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || fetch_fault !== 1'b0)
      begin errors++; $display("FAIL t6_next got addr=%h req=%b fault=%b exp 0 1 0", imem_addr, imem_req, fetch_fault); end
  endtask

  task automatic test_async_reset();
    #3 rst_n = 1'b0;
    #1;
    check_reset_values("areset");
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_misaligned();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100)
      begin errors++; $display("FAIL t5_pre got req=%b addr=%h exp 1 00000100", imem_req, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h202;
    tick();
    redirect = 1'b0;
    checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      begin errors++; $display("FAIL t5_drain got fault=%b req=%b addr=%h exp 1 1 00000100", fetch_fault, imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0)
      begin errors++; $display("FAIL t5_fault got req=%b valid=%b exp 0 0", imem_req, instr_valid); end
    redirect = 1'b1; redirect_pc = 32'h300; instr_ready = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      redirect = 1'b0;
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b1)
        begin errors++; $display("FAIL t5_stuck%0d got req=%b valid=%b fault=%b exp 0 0 1", i, imem_req, instr_valid, fetch_fault); end
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL t5_clear got %b exp 0", fetch_fault); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_redirect_pending();
    test_redirect_hold();
    test_pc_wrap();
    test_async_reset();
    test_misaligned();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
